// File: rtl/eth_cfg_pkt_tx.sv
// DDS configuration packet source for an Ethernet MAC: snapshots per-channel
// settings on a trigger and streams them word by word, closed by a checksum.
module eth_cfg_pkt_tx #(
  parameter int          NUM_CH      = 2,
  parameter logic [15:0] MAGIC       = 16'hD5D5,
  parameter int          RESEND_CYC  = 0,
  parameter int          TIMEOUT_CYC = 65535
) (
  input  logic                   eth_tx_clk,
  input  logic                   rst_n,
  input  logic                   dds_ctrl_en,
  input  logic [4*NUM_CH-1:0]    wave_select,
  input  logic [9*NUM_CH-1:0]    amp_ctl,
  input  logic [32*NUM_CH-1:0]   freq_ctl,
  input  logic [32*NUM_CH-1:0]   min_ctl,
  input  logic [12*NUM_CH-1:0]   phase_ctl,
  output logic                   tx_start_en,
  output logic [15:0]            tx_byte_num,
  output logic [31:0]            tx_data,
  input  logic                   tx_req,
  input  logic                   tx_done,
  output logic                   busy,
  output logic [7:0]             seq_num,
  output logic                   tx_err
);

  localparam int          NWORDS   = 5 * NUM_CH + 2;
  localparam logic [5:0]  LAST_IDX = 6'(NWORDS - 1);
  localparam logic [5:0]  END_IDX  = 6'(NWORDS);
  localparam logic [31:0] TO_LIM   = 32'(TIMEOUT_CYC);
  localparam logic [7:0]  NCH8     = 8'(NUM_CH);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  state_t r_state;
  state_t w_next;

  logic        r_en_p0, r_en_p1, r_en_p2;
  logic        r_pend;
  logic [7:0]  r_seq;
  logic [5:0]  r_wcnt;
  logic [31:0] r_to;
  logic [31:0] r_tx_data;
  logic [31:0] r_csum;

  logic [4*NUM_CH-1:0]  r_wave;
  logic [9*NUM_CH-1:0]  r_amp;
  logic [32*NUM_CH-1:0] r_freq;
  logic [32*NUM_CH-1:0] r_min;
  logic [12*NUM_CH-1:0] r_phase;

  logic        w_rise;
  logic        w_resend;
  logic        w_trig;
  logic [31:0] w_pkt [NWORDS-1];
  logic [31:0] w_word;

  // two-flop synchroniser, third flop only for edge detection
  assign w_rise = r_en_p1 & ~r_en_p2;
  assign w_trig = w_rise | w_resend;

  generate
    if (RESEND_CYC > 0) begin : g_resend
      localparam logic [31:0] RS_LIM = 32'(RESEND_CYC - 1);
      logic [31:0] r_rs_cnt;

      always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rs_cnt <= '0;
        end else if (r_rs_cnt == RS_LIM) begin
          r_rs_cnt <= '0;
        end else begin
          r_rs_cnt <= r_rs_cnt + 32'd1;
        end
      end

      assign w_resend = (r_rs_cnt == RS_LIM);
    end else begin : g_no_resend
      assign w_resend = 1'b0;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < NWORDS - 1; i++) begin
      w_pkt[i] = '0;
    end
    w_pkt[0] = {MAGIC, r_seq, NCH8};
    for (int c = 0; c < NUM_CH; c++) begin
      w_pkt[5*c+1] = {28'b0, r_wave[4*c +: 4]};
      w_pkt[5*c+2] = {23'b0, r_amp[9*c +: 9]};
      w_pkt[5*c+3] = r_freq[32*c +: 32];
      w_pkt[5*c+4] = r_min[32*c +: 32];
      w_pkt[5*c+5] = {20'b0, r_phase[12*c +: 12]};
    end
  end

  // past the checksum the counter sits at END_IDX and selects zero
  always_comb begin
    w_word = '0;
    if (r_wcnt == LAST_IDX) begin
      w_word = r_csum;
    end else begin
      for (int i = 0; i < NWORDS - 1; i++) begin
        if (r_wcnt == 6'(i)) begin
          w_word = w_pkt[i];
        end
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    tx_start_en = 1'b0;
    busy        = 1'b0;
    tx_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_trig || r_pend) begin
          w_next = START;
        end
      end
      START: begin
        tx_start_en = 1'b1;
        busy        = 1'b1;
        w_next      = XFER;
      end
      XFER: begin
        busy = 1'b1;
        if (tx_done) begin
          w_next = IDLE;
        end else if (r_to >= TO_LIM) begin
          tx_err = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge eth_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_en_p0   <= 1'b0;
      r_en_p1   <= 1'b0;
      r_en_p2   <= 1'b0;
      r_pend    <= 1'b0;
      r_seq     <= '0;
      r_wcnt    <= '0;
      r_to      <= '0;
      r_tx_data <= '0;
    end else begin
      r_state <= w_next;
      r_en_p0 <= dds_ctrl_en;
      r_en_p1 <= r_en_p0;
      r_en_p2 <= r_en_p1;
      // in IDLE any trigger is consumed by the move to START
      if (r_state == IDLE) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= r_pend | w_trig;
      end
      case (r_state)
        START: begin
          r_seq  <= r_seq + 8'd1;
          r_wcnt <= '0;
          r_to   <= 32'd1;
        end
        XFER: begin
          r_to <= r_to + 32'd1;
          if (tx_req) begin
            r_tx_data <= w_word;
            if (r_wcnt != END_IDX) begin
              r_wcnt <= r_wcnt + 6'd1;
            end
          end
        end
        default: r_to <= '0;
      endcase
    end
  end

  // config snapshot and running checksum
  always_ff @(posedge eth_tx_clk) begin
    if (r_state == START) begin
      r_wave  <= wave_select;
      r_amp   <= amp_ctl;
      r_freq  <= freq_ctl;
      r_min   <= min_ctl;
      r_phase <= phase_ctl;
      r_csum  <= '0;
    end else if (r_state == XFER && tx_req && r_wcnt < LAST_IDX) begin
      r_csum <= r_csum + w_word;
    end
  end

  assign tx_byte_num = 16'(4 * NWORDS);
  assign tx_data     = r_tx_data;
  assign seq_num     = r_seq;

endmodule

// File: tb/tb_eth_cfg_pkt_tx.sv
// Directed bench for eth_cfg_pkt_tx: one instance exercises triggers, timeout
// and reset; a second instance exercises the periodic resend timer.
module tb_eth_cfg_pkt_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_b, dds, b_dds;
  logic [7:0]  wave;
  logic [17:0] amp;
  logic [63:0] freq, minr;
  logic [23:0] phase;

  logic        a_start, a_req, a_done, a_busy, a_err;
  logic [15:0] a_bnum;
  logic [31:0] a_data;
  logic [7:0]  a_seq;
  logic        b_start, b_req, b_done, b_busy, b_err;
  logic [15:0] b_bnum;
  logic [31:0] b_data;
  logic [7:0]  b_seq;

  eth_cfg_pkt_tx #(.NUM_CH(2), .MAGIC(16'hD5D5), .RESEND_CYC(0), .TIMEOUT_CYC(100)) dut (
    .eth_tx_clk(clk), .rst_n(rst_n), .dds_ctrl_en(dds),
    .wave_select(wave), .amp_ctl(amp), .freq_ctl(freq), .min_ctl(minr), .phase_ctl(phase),
    .tx_start_en(a_start), .tx_byte_num(a_bnum), .tx_data(a_data),
    .tx_req(a_req), .tx_done(a_done), .busy(a_busy), .seq_num(a_seq), .tx_err(a_err));

  eth_cfg_pkt_tx #(.NUM_CH(2), .MAGIC(16'hD5D5), .RESEND_CYC(1000), .TIMEOUT_CYC(65535)) dut_rs (
    .eth_tx_clk(clk), .rst_n(rst_n_b), .dds_ctrl_en(b_dds),
    .wave_select(wave), .amp_ctl(amp), .freq_ctl(freq), .min_ctl(minr), .phase_ctl(phase),
    .tx_start_en(b_start), .tx_byte_num(b_bnum), .tx_data(b_data),
    .tx_req(b_req), .tx_done(b_done), .busy(b_busy), .seq_num(b_seq), .tx_err(b_err));

  typedef struct {
    string       name;
    logic [31:0] exp;
  } wvec_t;

  wvec_t tbl [12];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_start) seen = 1'b1;
    end
    chk({name, " start seen"}, 32'(seen), 32'd1);
  endtask

  task automatic trigger(input string name);
    @(negedge clk) dds = 1'b0;
    @(negedge clk) dds = 1'b1;
    wait_start(name);
  endtask

  // words 0 and 11 carry the sequence number in bits 15:8 relative to seq 1
  task automatic read_pkt(input logic [7:0] seq, input int n, input int gap, input bit chg);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      repeat (gap) @(negedge clk);
      @(negedge clk) a_req = 1'b1;
      @(negedge clk) a_req = 1'b0;
      if (i == 0) chk("seq_num", 32'(a_seq), 32'(seq));
      e = tbl[i].exp;
      if (i == 0 || i == 11) e = e + ((32'(seq) - 32'd1) << 8);
      chk(tbl[i].name, a_data, e);
      if (chg && i == 2) freq = 64'hDEAD_BEEF_CAFE_F00D;
    end
  endtask

  task automatic done_pulse();
    @(negedge clk) a_done = 1'b1;
    @(negedge clk) a_done = 1'b0;
    chk("busy after done", 32'(a_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int errc;
    int extra;
    int bc;
    int last;
    bit seen;

    rst_n = 1'b0; rst_n_b = 1'b0; dds = 1'b0; b_dds = 1'b0;
    a_req = 1'b0; a_done = 1'b0; b_req = 1'b0; b_done = 1'b0;
    wave  = {4'h2, 4'h1};
    amp   = {9'h080, 9'h100};
    freq  = {32'h0000_2000, 32'h0000_1000};
    minr  = {32'h0000_0020, 32'h0000_0010};
    phase = {12'h456, 12'h123};

    tbl[0]  = '{"w0 header",   32'hD5D5_0102};
    tbl[1]  = '{"w1 wave0",    32'h0000_0001};
    tbl[2]  = '{"w2 amp0",     32'h0000_0100};
    tbl[3]  = '{"w3 freq0",    32'h0000_1000};
    tbl[4]  = '{"w4 min0",     32'h0000_0010};
    tbl[5]  = '{"w5 phase0",   32'h0000_0123};
    tbl[6]  = '{"w6 wave1",    32'h0000_0002};
    tbl[7]  = '{"w7 amp1",     32'h0000_0080};
    tbl[8]  = '{"w8 freq1",    32'h0000_2000};
    tbl[9]  = '{"w9 min1",     32'h0000_0020};
    tbl[10] = '{"w10 phase1",  32'h0000_0456};
    tbl[11] = '{"w11 checksum", 32'hD5D5_382E};

    repeat (3) @(negedge clk);
    chk("reset tx_start_en", 32'(a_start), 32'd0);
    chk("reset busy", 32'(a_busy), 32'd0);
    chk("reset seq_num", 32'(a_seq), 32'd0);
    chk("reset tx_data", a_data, 32'd0);
    chk("reset tx_err", 32'(a_err), 32'd0);
    chk("tx_byte_num", 32'(a_bnum), 32'd48);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle after reset", 32'(a_busy), 32'd0);

    // first packet: trigger latency, full word sequence, read past checksum
    @(negedge clk) dds = 1'b1;
    @(negedge clk) chk("latency cycle 1", 32'(a_start), 32'd0);
    @(negedge clk) chk("latency cycle 2", 32'(a_start), 32'd0);
    @(negedge clk) chk("latency cycle 3", 32'(a_start), 32'd1);
    chk("busy in START", 32'(a_busy), 32'd1);
    read_pkt(8'd1, 12, 0, 1'b0);
    @(negedge clk) a_req = 1'b1;
    @(negedge clk) a_req = 1'b0;
    chk("req past checksum", a_data, 32'd0);
    done_pulse();

    // second packet: two more rises coalesce, freq change mid-flight ignored
    trigger("pkt2");
    for (int k = 0; k < 4; k++) begin
      repeat (2) @(negedge clk);
      dds = ~dds;
    end
    repeat (2) @(negedge clk);
    dds = 1'b0;
    read_pkt(8'd2, 12, 1, 1'b1);
    freq = {32'h0000_2000, 32'h0000_1000};
    done_pulse();
    wait_start("pkt3 pending");
    read_pkt(8'd3, 12, 0, 1'b0);

    // trigger landing on the same edge as tx_done
    @(negedge clk) dds = 1'b1;
    @(negedge clk);
    @(negedge clk) a_done = 1'b1;
    @(negedge clk) a_done = 1'b0;
    chk("busy at coincident done", 32'(a_busy), 32'd0);
    wait_start("pkt4 coincident");
    read_pkt(8'd4, 12, 0, 1'b0);
    done_pulse();
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_start) extra++;
    end
    chk("no extra packet", 32'(extra), 32'd0);

    // timeout with a trigger pending
    trigger("pkt5");
    errc = -1;
    for (int cyc = 1; cyc <= 150 && errc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_req = 1'b1;
      if (cyc == 2) a_req = 1'b0;
      if (cyc == 3) dds = 1'b0;
      if (cyc == 5) dds = 1'b1;
      if (a_err) errc = cyc;
    end
    chk("timeout latency", 32'(errc), 32'd100);
    @(negedge clk);
    chk("busy after timeout", 32'(a_busy), 32'd0);
    chk("tx_err single cycle", 32'(a_err), 32'd0);
    a_req = 1'b1;
    @(negedge clk) a_req = 1'b0;
    chk("req ignored in IDLE", a_data, 32'hD5D5_0502);
    chk("pending after timeout", 32'(a_start), 32'd1);
    read_pkt(8'd6, 12, 0, 1'b0);
    done_pulse();

    // reset in the middle of a packet
    trigger("pkt7");
    read_pkt(8'd7, 5, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    dds = 1'b0;
    #1;
    chk("mid reset tx_data", a_data, 32'd0);
    chk("mid reset busy", 32'(a_busy), 32'd0);
    chk("mid reset seq_num", 32'(a_seq), 32'd0);
    chk("mid reset tx_start_en", 32'(a_start), 32'd0);
    chk("mid reset tx_err", 32'(a_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle after mid reset", 32'(a_busy), 32'd0);
    trigger("post reset");
    read_pkt(8'd1, 12, 0, 1'b0);
    done_pulse();

    // periodic resend instance
    bc = 0;
    last = 0;
    @(negedge clk) rst_n_b = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 1100 && !seen; i++) begin
        @(negedge clk);
        bc++;
        if (b_start) seen = 1'b1;
      end
      chk("resend start seen", 32'(seen), 32'd1);
      chk("resend interval", 32'(bc - last), 32'd1000);
      last = bc;
      @(negedge clk);
      bc++;
      chk("resend seq_num", 32'(b_seq), 32'(k));
      repeat (3) begin
        @(negedge clk);
        bc++;
      end
      @(negedge clk) b_done = 1'b1;
      bc++;
      @(negedge clk) b_done = 1'b0;
      bc++;
      chk("resend busy after done", 32'(b_busy), 32'd0);
    end
    chk("resend tx_err", 32'(b_err), 32'd0);
    chk("resend tx_data untouched", b_data, 32'd0);
    chk("resend tx_byte_num", 32'(b_bnum), 32'd48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_cfg_pkt_tx.md
ETH_CFG_PKT_TX -- requirements
Module: eth_cfg_pkt_tx

Interface
REQ-001 Parameter NUM_CH, default 2, number of DDS channels carried per packet (legal 1..8).
REQ-002 Parameter MAGIC, default 16'hD5D5, packet header tag.
REQ-003 Parameter RESEND_CYC, default 0, periodic resend interval in eth_tx_clk cycles; 0 disables.
REQ-004 Parameter TIMEOUT_CYC, default 65535, maximum cycles from tx_start_en to tx_done before abort.
REQ-005 Clock and reset: eth_tx_clk is the clock; rst_n is an asynchronous, active-low reset.
REQ-006 eth_tx_clk  in  1  clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 dds_ctrl_en  in  1  send trigger, asynchronous level, rising edge requests one packet.
REQ-009 wave_select  in  4*NUM_CH  per-channel waveform select, channel 0 in LSBs (same packing for all config buses).
REQ-010 amp_ctl  in  9*NUM_CH  per-channel amplitude.
REQ-011 freq_ctl  in  32*NUM_CH  per-channel frequency word.
REQ-012 min_ctl  in  32*NUM_CH  per-channel minimum resolution.
REQ-013 phase_ctl  in  12*NUM_CH  per-channel phase.
REQ-014 tx_start_en  out  1  one-cycle pulse starting an Ethernet frame.
REQ-015 tx_byte_num  out  16  payload bytes = 4*(5*NUM_CH+2), constant.
REQ-016 tx_data  out  32  payload word, registered.
REQ-017 tx_req  in  1  MAC word request.
REQ-018 tx_done  in  1  MAC frame-complete pulse.
REQ-019 busy  out  1  high from START through frame end.
REQ-020 seq_num  out  8  sequence number of last started packet.
REQ-021 tx_err  out  1  one-cycle pulse on timeout abort.

Function
REQ-022 dds_ctrl_en shall be synchronised by two flops; a rising edge of the synchronised signal shall raise a trigger request.
REQ-023 When RESEND_CYC>0, a free-running counter shall raise a trigger request each time it reaches RESEND_CYC-1 and wraps to 0.
REQ-024 FSM states: IDLE, START, XFER; IDLE->START when a trigger is pending; START->XFER unconditionally after one cycle; XFER->IDLE on tx_done or on timeout.
REQ-025 In START: tx_start_en=1 for exactly that cycle; all config inputs shall be snapshotted; seq_num shall increment by 1 (wraps 255->0); word counter and checksum shall clear.
REQ-026 Packet words, in order: W0={MAGIC, seq_num, NUM_CH[7:0]}; then per channel c=0..NUM_CH-1: {28'b0,wave}, {23'b0,amp}, freq, min, {20'b0,phase}; last word = checksum.
REQ-027 Checksum shall be the modulo-2^32 sum of all preceding words of the packet.
REQ-028 On each tx_req in XFER, tx_data shall update on the next clock edge to the word indexed by the word counter, and the counter shall increment; tx_data is valid one cycle after tx_req.
REQ-029 tx_req after the checksum word shall load tx_data=0 and leave the counter saturated.
REQ-030 tx_req outside XFER shall be ignored (tx_data holds).
REQ-031 Trigger arriving while busy shall set a single pending flag (further triggers coalesce); the packet is sent after return to IDLE.
REQ-032 Trigger coinciding with tx_done shall be kept pending, not lost.
REQ-033 Timeout counter shall start at START; reaching TIMEOUT_CYC in XFER without tx_done shall pulse tx_err and return to IDLE; pending trigger is retained.
REQ-034 Config input changes during XFER shall not affect the packet in flight.

Reset
REQ-035 On rst_n low: state IDLE, tx_start_en=0, tx_data=0, busy=0, seq_num=0, tx_err=0, pending=0, all counters=0, synchroniser flops=0 (no spurious trigger after reset).
REQ-036 Reset asserted mid-packet shall abort immediately with all outputs at reset values.

Verification
REQ-037 NUM_CH=2, wave={4'h2,4'h1}, amp=9'h100/9'h080, freq=32'h1000/32'h2000; rise dds_ctrl_en -> tx_start_en pulse 3 cycles later, tx_byte_num=48, W0=32'hD5D5_0102, 12 words, checksum equals sum of words 0..10.
REQ-038 Second rise of dds_ctrl_en during XFER, then extra rises -> exactly one further packet, seq_num=2.
REQ-039 RESEND_CYC=1000, dds_ctrl_en held low -> packets every 1000 cycles when tx_done returns within interval; seq_num increments by 1 each.
REQ-040 TIMEOUT_CYC=100, tx_done never asserted -> tx_err pulse 100 cycles after START, busy=0, next trigger sends seq_num+1.
REQ-041 Change freq_ctl mid-XFER -> transmitted freq words equal the START snapshot.
REQ-042 rst_n pulsed low at word 5 of a packet -> all outputs zero, seq_num=0, next trigger yields W0=32'hD5D5_0102.
